// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus: registered one-hot
// driver enables, bounded tenure and an all-Z turnaround gap between owners.
module tri_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_HOLD   = 4,
    parameter int TURNAROUND = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         last,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         oe,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       bus_busy,
    output logic                       bus_z,
    output logic [3:0]                 beat_cnt
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int IW  = IDW + 1;

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    typedef struct packed {
        logic           found;
        logic [IDW-1:0] idx;
    } arb_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] oe_q;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               busy_q, busy_d;
    logic [3:0]         beat_q, beat_d;
    logic [1:0]         turn_q, turn_d;

    logic [IDW-1:0]     next_ptr;
    logic [IDW-1:0]     arb_start;
    logic [3:0]         beat_inc;
    logic               release_now;
    logic               do_arb;
    arb_t               arb;

    // First set request at or after start, wrapping with an explicit compare
    // so non-power-of-two requester counts stay in range.
    function automatic arb_t arbitrate(input logic [NUM_REQ-1:0] r,
                                       input logic [IDW-1:0]     start);
        arb_t          res;
        logic [IW-1:0] idx;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, start} + IW'(i);
            if (idx >= IW'(NUM_REQ)) begin
                idx = idx - IW'(NUM_REQ);
            end
            if (!res.found && r[idx[IDW-1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[IDW-1:0];
            end
        end
        return res;
    endfunction

    assign next_ptr  = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + IDW'(1);
    assign beat_inc  = beat_q + 4'd1;
    // A release with no turnaround re-arbitrates from the pointer it is about to write.
    assign arb_start = (state_q == GRANT) ? next_ptr : rr_ptr_q;
    assign arb       = arbitrate(req, arb_start);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        beat_d      = beat_q;
        turn_d      = turn_q;
        release_now = 1'b0;
        do_arb      = 1'b0;

        unique case (state_q)
            IDLE: do_arb = 1'b1;
            GRANT: begin
                if (!req[owner_q]) begin
                    release_now = 1'b1;
                end else begin
                    beat_d      = beat_inc;
                    release_now = last[owner_q] || (beat_inc == 4'(MAX_HOLD));
                end
            end
            TURN: begin
                if (turn_q <= 2'd1) begin
                    do_arb = 1'b1;
                end else begin
                    turn_d = turn_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (release_now) begin
            gnt_d    = '0;
            busy_d   = 1'b0;
            rr_ptr_d = next_ptr;
            if (TURNAROUND > 0) begin
                state_d = TURN;
                turn_d  = 2'(TURNAROUND);
            end else begin
                do_arb = 1'b1;
            end
        end

        if (do_arb) begin
            if (arb.found) begin
                state_d = GRANT;
                gnt_d   = NUM_REQ'(1) << arb.idx;
                owner_d = arb.idx;
                busy_d  = 1'b1;
                beat_d  = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            oe_q     <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
            beat_q   <= '0;
            turn_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            oe_q     <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            beat_q   <= beat_d;
            turn_q   <= turn_d;
        end
    end

    assign gnt      = gnt_q;
    assign oe       = oe_q;
    assign owner_id = owner_q;
    assign bus_busy = busy_q;
    assign bus_z    = ~|oe_q;
    assign beat_cnt = beat_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Vector-table bench for tri_bus_arbiter: one instance with a one-cycle
// turnaround, one with back-to-back grants, expected outputs via a scoreboard.
module tb_tri_bus_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] oe;
        logic [1:0] owner;
        logic       busy;
        logic       bz;
        logic [3:0] beat;
    } obs_t;

    typedef struct {
        bit         b2b;
        logic [3:0] req;
        logic [3:0] last;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic [3:0] beat;
    } vec_t;

    typedef struct {
        bit   b2b;
        obs_t obs;
        int   step;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a, last_a, gnt_a, oe_a, beat_a;
    logic [1:0] owner_a;
    logic       busy_a, bz_a;
    logic [3:0] req_b, last_b, gnt_b, oe_b, beat_b;
    logic [1:0] owner_b;
    logic       busy_b, bz_b;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step  = 0;

    always #5 clk = ~clk;

    tri_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(4), .TURNAROUND(1)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .last(last_a),
        .gnt(gnt_a), .oe(oe_a), .owner_id(owner_a), .bus_busy(busy_a),
        .bus_z(bz_a), .beat_cnt(beat_a)
    );

    tri_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(4), .TURNAROUND(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .last(last_b),
        .gnt(gnt_b), .oe(oe_b), .owner_id(owner_b), .bus_busy(busy_b),
        .bus_z(bz_b), .beat_cnt(beat_b)
    );

    function automatic obs_t mk_obs(logic [3:0] g, logic [1:0] o, logic [3:0] b);
        obs_t r;
        r.gnt   = g;
        r.oe    = g;
        r.owner = o;
        r.busy  = |g;
        r.bz    = ~|g;
        r.beat  = b;
        return r;
    endfunction

    function automatic obs_t observe(bit b2b);
        if (b2b) return {gnt_b, oe_b, owner_b, busy_b, bz_b, beat_b};
        return {gnt_a, oe_a, owner_a, busy_a, bz_a, beat_a};
    endfunction

    task automatic check(string name, obs_t act, obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b oe=%b owner=%0d busy=%b bus_z=%b beat=%0d, want gnt=%b oe=%b owner=%0d busy=%b bus_z=%b beat=%0d",
                     name, act.gnt, act.oe, act.owner, act.busy, act.bz, act.beat,
                     exp.gnt, exp.oe, exp.owner, exp.busy, exp.bz, exp.beat);
        end
    endtask

    task automatic add_vec(bit b2b, logic [3:0] rq, logic [3:0] lst,
                           logic [3:0] g, logic [1:0] o, logic [3:0] b);
        vecs.push_back('{b2b: b2b, req: rq, last: lst, gnt: g, owner: o, beat: b});
    endtask

    task automatic score();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue, want a pending entry");
        end else begin
            e = exp_q.pop_front();
            check($sformatf("%s step %0d", e.b2b ? "u_b" : "u_a", e.step), observe(e.b2b), e.obs);
        end
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            if (vecs[i].b2b) begin
                req_b = vecs[i].req;  last_b = vecs[i].last;
                req_a = '0;           last_a = '0;
            end else begin
                req_a = vecs[i].req;  last_a = vecs[i].last;
                req_b = '0;           last_b = '0;
            end
            step++;
            exp_q.push_back('{b2b: vecs[i].b2b,
                              obs: mk_obs(vecs[i].gnt, vecs[i].owner, vecs[i].beat),
                              step: step});
            @(posedge clk);
            #1;
            score();
        end
        vecs.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset pulse u_a", observe(1'b0), mk_obs(4'b0, 2'd0, 4'd0));
        check("reset pulse u_b", observe(1'b1), mk_obs(4'b0, 2'd0, 4'd0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = '0; last_a = '0;
        req_b = '0; last_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset u_a", observe(1'b0), mk_obs(4'b0, 2'd0, 4'd0));
        check("reset u_b", observe(1'b1), mk_obs(4'b0, 2'd0, 4'd0));
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted between edges while requester 2 owns the bus
        add_vec(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 4'd0);
        add_vec(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 4'd1);
        run_vecs();
        #2 rst_n = 1'b0;
        #1;
        check("async reset mid-tenure", observe(1'b0), mk_obs(4'b0, 2'd0, 4'd0));
        @(negedge clk);
        rst_n = 1'b1;
        add_vec(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 4'd0);
        add_vec(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'd0);
        add_vec(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'd0);

        // Single requester: four beats, one Z cycle, re-grant, then drop
        for (int b = 0; b < 4; b++) add_vec(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 4'(b));
        add_vec(0, 4'b0010, 4'b0000, 4'b0000, 2'd1, 4'd4);
        add_vec(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 4'd0);
        add_vec(0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 4'd0);
        add_vec(0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 4'd0);

        // Early release: last on second beat, then request dropped after one beat
        add_vec(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 4'd0);
        add_vec(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 4'd1);
        add_vec(0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 4'd2);
        add_vec(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 4'd2);
        add_vec(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 4'd0);
        add_vec(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 4'd1);
        add_vec(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 4'd1);
        add_vec(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 4'd1);

        // Non-owner last and request ignored; req[0] raised during TURN
        add_vec(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 4'd0);
        add_vec(0, 4'b0010, 4'b1000, 4'b0010, 2'd1, 4'd1);
        add_vec(0, 4'b1010, 4'b1000, 4'b0010, 2'd1, 4'd2);
        add_vec(0, 4'b1010, 4'b0010, 4'b0000, 2'd1, 4'd3);
        add_vec(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 4'd0);
        add_vec(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'd0);
        add_vec(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'd0);
        run_vecs();

        // Fairness: all requesting, owners rotate 0,1,2,3,0
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 4; b++) add_vec(0, 4'b1111, 4'b0000, 4'(1 << k), 2'(k), 4'(b));
            add_vec(0, 4'b1111, 4'b0000, 4'b0000, 2'(k), 4'd4);
        end
        add_vec(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 4'd0);

        // Zero turnaround: 0001 then 0010 on consecutive cycles, no Z gap
        for (int b = 0; b < 4; b++) add_vec(1, 4'b0011, 4'b0000, 4'b0001, 2'd0, 4'(b));
        for (int b = 0; b < 4; b++) add_vec(1, 4'b0011, 4'b0000, 4'b0010, 2'd1, 4'(b));
        add_vec(1, 4'b0011, 4'b0000, 4'b0001, 2'd0, 4'd0);
        add_vec(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'd0);
        add_vec(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'd0);
        run_vecs();

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
